// File: rtl/jpeg_rle_encoder_pkg.sv
// Shared types, constants and coding helpers for the JPEG run-length/size encoder.
// Coefficients are signed; amplitudes use the JPEG one's-complement style coding.
package jpeg_rle_encoder_pkg;

  typedef enum logic [2:0] {
    IDLE, PRIME, DC, SCAN, ZRL, AC, EOB, DONE
  } state_t;

  localparam logic [7:0] RUNSIZE_ZRL = 8'hF0;
  localparam logic [7:0] RUNSIZE_EOB = 8'h00;
  localparam int         DC_SAT      = 2047;
  localparam int         AC_SAT      = 1023;

  // Bit length of a magnitude: 0 -> 0, 1 -> 1, 2..3 -> 2, ... 1024..2047 -> 11.
  function automatic logic [3:0] size_cat(input logic [10:0] mag);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 11; i++)
      if (mag[i]) s = 4'(i + 1);
    return s;
  endfunction

  // Negative values send the low size bits of v-1; bits above size are zeroed.
  function automatic logic [10:0] amp_code(input logic signed [11:0] v,
                                           input logic [3:0]         size);
    logic [11:0] t;
    logic [11:0] m;
    t = (v < 12'sd0) ? 12'(v - 12'sd1) : 12'(v);
    m = (12'd1 << size) - 12'd1;
    return t[10:0] & m[10:0];
  endfunction

endpackage

// File: rtl/jpeg_rle_encoder_zigzag.sv
// Combinational zig-zag scan index to row-major index of an 8x8 block.
// Walks the 15 anti-diagonals; even diagonals run bottom-left to top-right.
module zig_zag_to_row_major (
  input  logic [5:0] zz_index,
  output logic [5:0] rm_index
);

  int idx, base, len, off, row, col;

  always_comb begin
    idx  = int'(zz_index);
    base = 0;
    len  = 0;
    off  = 0;
    row  = 0;
    col  = 0;
    for (int d = 0; d < 15; d++) begin
      len = (d < 8) ? d + 1 : 15 - d;
      if (idx >= base && idx < base + len) begin
        off = idx - base;
        if (d % 2 == 0) begin
          row = ((d < 7) ? d : 7) - off;
          col = d - row;
        end else begin
          col = ((d < 7) ? d : 7) - off;
          row = d - col;
        end
      end
      base = base + len;
    end
    rm_index = 6'(row * 8 + col);
  end

endmodule

// File: rtl/jpeg_rle_encoder.sv
// JPEG entropy front end: reads a quantized 8x8 block in zig-zag order and emits
// DC difference, ZRL, AC {run,size} and EOB symbols with amplitude bits.
module jpeg_rle_encoder
  import jpeg_rle_encoder_pkg::*;
#(
  parameter int COEF_W    = 16,
  parameter int BUF_SEL_W = 2
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 frame_start,
  input  logic                 block_valid,
  input  logic [BUF_SEL_W-1:0] block_sel,
  output logic                 block_done,
  output logic [BUF_SEL_W+5:0] coef_raddr,
  input  logic [COEF_W-1:0]    coef_rdata,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic [7:0]           sym_runsize,
  output logic [10:0]          sym_amp,
  output logic                 sym_is_dc,
  output logic                 sym_last
);

  localparam logic signed [COEF_W:0]   DC_HI = (COEF_W+1)'(DC_SAT);
  localparam logic signed [COEF_W:0]   DC_LO = -DC_HI;
  localparam logic signed [COEF_W-1:0] AC_HI = COEF_W'(AC_SAT);
  localparam logic signed [COEF_W-1:0] AC_LO = -AC_HI;

  state_t                 state;
  logic [BUF_SEL_W-1:0]   sel;
  logic [5:0]             k, run, zz_in, rm_idx;
  logic [1:0]             dc_ph;
  logic signed [COEF_W-1:0] pred, dc_coef, coef;
  logic [3:0]             ac_size;
  logic [10:0]            ac_amp;
  logic                   ac_last;

  logic signed [COEF_W:0] diff_full;
  logic signed [11:0]     dc_diff, ac_v, dc_neg, ac_neg;
  logic [10:0]            dc_mag, ac_mag, dc_amp, ac_am;
  logic [3:0]             dc_size, ac_sz;

  assign coef = coef_rdata;

  always_comb begin
    diff_full = {coef[COEF_W-1], coef} - {pred[COEF_W-1], pred};
    if (diff_full > DC_HI)      dc_diff = 12'sd2047;
    else if (diff_full < DC_LO) dc_diff = -12'sd2047;
    else                        dc_diff = diff_full[11:0];
    if (coef > AC_HI)      ac_v = 12'sd1023;
    else if (coef < AC_LO) ac_v = -12'sd1023;
    else                   ac_v = coef[11:0];
    dc_neg  = -dc_diff;
    ac_neg  = -ac_v;
    dc_mag  = dc_diff[11] ? dc_neg[10:0] : dc_diff[10:0];
    ac_mag  = ac_v[11] ? ac_neg[10:0] : ac_v[10:0];
    dc_size = size_cat(dc_mag);
    ac_sz   = size_cat(ac_mag);
    dc_amp  = amp_code(dc_diff, dc_size);
    ac_am   = amp_code(ac_v, ac_sz);
  end

  // The read address always runs one zig-zag index ahead of the data being scanned.
  always_comb begin
    if (state == PRIME)                    zz_in = 6'd0;
    else if (state == DC && dc_ph != 2'd2) zz_in = 6'd1;
    else                                   zz_in = k + 6'd2;
  end

  zig_zag_to_row_major u_zz (
    .zz_index (zz_in),
    .rm_index (rm_idx)
  );

  // A symbol transfers on a clock edge where sym_valid and sym_ready are both 1;
  // while sym_valid is held without sym_ready, sym_* and coef_raddr do not change.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      sel         <= '0;
      k           <= '0;
      run         <= '0;
      dc_ph       <= '0;
      pred        <= '0;
      dc_coef     <= '0;
      ac_size     <= '0;
      ac_amp      <= '0;
      ac_last     <= 1'b0;
      block_done  <= 1'b0;
      coef_raddr  <= '0;
      sym_valid   <= 1'b0;
      sym_runsize <= '0;
      sym_amp     <= '0;
      sym_is_dc   <= 1'b0;
      sym_last    <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: if (block_valid) begin
          sel   <= block_sel;
          k     <= '0;
          run   <= '0;
          dc_ph <= '0;
          state <= PRIME;
        end
        PRIME: begin
          coef_raddr <= {sel, rm_idx};
          state      <= DC;
        end
        DC: begin
          if (dc_ph == 2'd0) begin
            dc_ph <= 2'd1;
          end else if (dc_ph == 2'd1) begin
            dc_ph       <= 2'd2;
            dc_coef     <= coef;
            coef_raddr  <= {sel, rm_idx};
            sym_valid   <= 1'b1;
            sym_is_dc   <= 1'b1;
            sym_last    <= 1'b0;
            sym_runsize <= {4'd0, dc_size};
            sym_amp     <= dc_amp;
          end else if (sym_ready) begin
            pred       <= dc_coef;
            sym_valid  <= 1'b0;
            sym_is_dc  <= 1'b0;
            k          <= 6'd1;
            coef_raddr <= {sel, rm_idx};
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (coef == '0) begin
            if (k == 6'd63) begin
              sym_valid   <= 1'b1;
              sym_runsize <= RUNSIZE_EOB;
              sym_amp     <= '0;
              sym_last    <= 1'b1;
              state       <= EOB;
            end else begin
              run        <= run + 6'd1;
              k          <= k + 6'd1;
              coef_raddr <= {sel, rm_idx};
            end
          end else begin
            ac_size   <= ac_sz;
            ac_amp    <= ac_am;
            ac_last   <= (k == 6'd63);
            sym_valid <= 1'b1;
            if (run >= 6'd16) begin
              sym_runsize <= RUNSIZE_ZRL;
              sym_amp     <= '0;
              sym_last    <= 1'b0;
              state       <= ZRL;
            end else begin
              sym_runsize <= {run[3:0], ac_sz};
              sym_amp     <= ac_am;
              sym_last    <= (k == 6'd63);
              state       <= AC;
            end
          end
        end
        ZRL: if (sym_ready) begin
          // Subtracting 16 leaves run[3:0] untouched, so it is already the AC run.
          run <= run - 6'd16;
          if (run < 6'd32) begin
            sym_runsize <= {run[3:0], ac_size};
            sym_amp     <= ac_amp;
            sym_last    <= ac_last;
            state       <= AC;
          end
        end
        AC: if (sym_ready) begin
          run       <= '0;
          sym_valid <= 1'b0;
          if (ac_last) begin
            block_done <= 1'b1;
            state      <= DONE;
          end else begin
            k          <= k + 6'd1;
            coef_raddr <= {sel, rm_idx};
            state      <= SCAN;
          end
        end
        EOB: if (sym_ready) begin
          sym_valid  <= 1'b0;
          block_done <= 1'b1;
          state      <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // Frame start wins over a same-cycle DC accept.
      if (frame_start) pred <= '0;
    end
  end

endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// Directed bench for jpeg_rle_encoder: blocks are written into a synchronous
// coefficient memory model and the accepted symbol stream is scored in order.
module tb_jpeg_rle_encoder;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        frame_start = 1'b0;
  logic        block_valid = 1'b0;
  logic [1:0]  block_sel = 2'd0;
  logic        sym_ready = 1'b0;
  logic        block_done, sym_valid, sym_is_dc, sym_last;
  logic [7:0]  coef_raddr, sym_runsize;
  logic [15:0] coef_rdata;
  logic [10:0] sym_amp;

  logic signed [15:0] mem [256];
  int zz_tab [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [20:0] exp_q[$];
  logic [20:0] want_sym;
  logic [29:0] cur_out, prev_out;
  logic        hold_prev = 1'b0;
  int n_vec = 0, n_err = 0, done_cnt = 0, stall_pct = 0;

  jpeg_rle_encoder #(.COEF_W(16), .BUF_SEL_W(2)) dut (
    .clock       (clock),
    .nreset      (nreset),
    .frame_start (frame_start),
    .block_valid (block_valid),
    .block_sel   (block_sel),
    .block_done  (block_done),
    .coef_raddr  (coef_raddr),
    .coef_rdata  (coef_rdata),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_runsize (sym_runsize),
    .sym_amp     (sym_amp),
    .sym_is_dc   (sym_is_dc),
    .sym_last    (sym_last)
  );

  // clock / memory model
  always #5 clock = ~clock;
  always @(posedge clock) coef_rdata <= mem[coef_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [20:0] sym(input bit dc, input bit last,
                                      input logic [7:0] rs, input logic [10:0] amp);
    return {dc, last, rs, amp};
  endfunction

  // scoreboard: symbols accepted at the coming edge, plus stall stability
  always @(negedge clock) begin
    cur_out = {sym_valid, sym_is_dc, sym_last, sym_runsize, sym_amp, coef_raddr};
    if (hold_prev) check("stall_hold", 32'(cur_out), 32'(prev_out));
    if (nreset && block_done) done_cnt++;
    if (nreset && sym_valid && sym_ready) begin
      check("sym_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want_sym = exp_q.pop_front();
        check("sym", 32'({sym_is_dc, sym_last, sym_runsize, sym_amp}), 32'(want_sym));
      end
    end
    hold_prev = nreset && sym_valid && !sym_ready;
    prev_out  = cur_out;
  end

  // driver tasks
  initial forever begin
    @(posedge clock); #1;
    sym_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
  end

  task automatic clear_block(input logic [1:0] sel);
    for (int i = 0; i < 64; i++) mem[{sel, 6'(i)}] = 16'sd0;
  endtask

  task automatic set_zz(input logic [1:0] sel, input int zz, input int val);
    mem[{sel, 6'(zz_tab[zz])}] = 16'(val);
  endtask

  task automatic pulse_frame();
    @(posedge clock); #1 frame_start = 1'b1;
    @(posedge clock); #1 frame_start = 1'b0;
  endtask

  task automatic run_block(input logic [1:0] sel, input bit fs_at_dc);
    int cnt;
    done_cnt = 0;
    @(posedge clock); #1;
    block_sel   = sel;
    block_valid = 1'b1;
    cnt = 0;
    do begin @(posedge clock); #1; cnt++; end while (!sym_valid && cnt < 20);
    check("dc_latency", 32'(cnt - 1), 32'd3);
    if (fs_at_dc) begin
      frame_start = 1'b1;
      @(posedge clock); #1 frame_start = 1'b0;
    end
    cnt = 0;
    while (!block_done && cnt < 2000) begin @(posedge clock); #1; cnt++; end
    check("block_done", 32'(block_done), 32'd1);
    block_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(sym_valid), 32'd0);
    check({tag, "_done"}, 32'(block_done), 32'd0);
    check({tag, "_raddr"}, 32'(coef_raddr), 32'd0);
    check({tag, "_runsize"}, 32'(sym_runsize), 32'd0);
    check({tag, "_amp"}, 32'(sym_amp), 32'd0);
    check({tag, "_is_dc"}, 32'(sym_is_dc), 32'd0);
    check({tag, "_last"}, 32'(sym_last), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 4; s++) clear_block(2'(s));
    #2 nreset = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1 nreset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("release_valid", 32'(sym_valid), 32'd0);
    end
    pulse_frame();

    // all-zero block: DC 0x00 then EOB
    exp_q.push_back(sym(1, 0, 8'h00, 11'd0));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd0, 1'b0);

    // DC=5: diff 5, size 3
    clear_block(2'd1); set_zz(2'd1, 0, 5);
    exp_q.push_back(sym(1, 0, 8'h03, 11'd5));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd1, 1'b0);

    // DC=-3 after 5: diff -8, size 4, amp 0111
    clear_block(2'd2); set_zz(2'd2, 0, -3);
    exp_q.push_back(sym(1, 0, 8'h04, 11'h007));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd2, 1'b0);

    // zz1=-1, zz20=3: {0,1} amp 0, ZRL, {2,2} amp 3, EOB
    pulse_frame();
    clear_block(2'd3); set_zz(2'd3, 1, -1); set_zz(2'd3, 20, 3);
    exp_q.push_back(sym(1, 0, 8'h00, 11'd0));
    exp_q.push_back(sym(0, 0, 8'h01, 11'd0));
    exp_q.push_back(sym(0, 0, 8'hF0, 11'd0));
    exp_q.push_back(sym(0, 0, 8'h22, 11'd3));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd3, 1'b0);

    // zz63=7 only: 3x ZRL then {E,3} last, no EOB
    clear_block(2'd0); set_zz(2'd0, 63, 7);
    exp_q.push_back(sym(1, 0, 8'h00, 11'd0));
    repeat (3) exp_q.push_back(sym(0, 0, 8'hF0, 11'd0));
    exp_q.push_back(sym(0, 1, 8'hE3, 11'd7));
    run_block(2'd0, 1'b0);

    // DC=100, zz2=5000 (clamps to 1023), zz5=-2; unstalled then stalled
    clear_block(2'd1); set_zz(2'd1, 0, 100); set_zz(2'd1, 2, 5000); set_zz(2'd1, 5, -2);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_frame();
      exp_q.push_back(sym(1, 0, 8'h07, 11'd100));
      exp_q.push_back(sym(0, 0, 8'h1A, 11'h3FF));
      exp_q.push_back(sym(0, 0, 8'h22, 11'd1));
      exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
      stall_pct = (pass == 0) ? 0 : 40;
      run_block(2'd1, 1'b0);
    end
    stall_pct = 0;

    // DC=-3000 after pred 100: diff saturates to -2047; zz63=-5000 clamps to -1023
    clear_block(2'd2); set_zz(2'd2, 0, -3000); set_zz(2'd2, 63, -5000);
    exp_q.push_back(sym(1, 0, 8'h0B, 11'd0));
    repeat (3) exp_q.push_back(sym(0, 0, 8'hF0, 11'd0));
    exp_q.push_back(sym(0, 1, 8'hEA, 11'd0));
    run_block(2'd2, 1'b0);

    // DC=50 after -3000 saturates to +2047; frame_start lands on the DC accept
    clear_block(2'd3); set_zz(2'd3, 0, 50);
    exp_q.push_back(sym(1, 0, 8'h0B, 11'h7FF));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd3, 1'b1);

    // pred must now be 0: DC=7 -> size 3 amp 7
    clear_block(2'd0); set_zz(2'd0, 0, 7);
    exp_q.push_back(sym(1, 0, 8'h03, 11'd7));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd0, 1'b0);

    // reset mid-SCAN: DC=20 after pred 7 (diff 13) is taken, then block aborted
    clear_block(2'd3); set_zz(2'd3, 0, 20); set_zz(2'd3, 63, 7);
    exp_q.push_back(sym(1, 0, 8'h04, 11'd13));
    done_cnt = 0;
    @(posedge clock); #1;
    block_sel   = 2'd3;
    block_valid = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    nreset      = 1'b0;
    block_valid = 1'b0;
    @(negedge clock);
    check_outputs_zero("mid_reset");
    check("mid_reset_dc_taken", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1 nreset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("mid_release_valid", 32'(sym_valid), 32'd0);
    end
    check("mid_reset_no_done", 32'(done_cnt), 32'd0);

    // next block after reset encodes with pred 0: DC=9 -> size 4 amp 9
    clear_block(2'd1); set_zz(2'd1, 0, 9);
    exp_q.push_back(sym(1, 0, 8'h04, 11'd9));
    exp_q.push_back(sym(0, 1, 8'h00, 11'd0));
    run_block(2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
